// File: rtl/ysyx_23060075_mc_sequencer.sv
// ysyx_23060075_mc_sequencer
//   Multi-cycle instruction sequencer. Each instruction is stepped through
//   IF -> IF_W -> EX -> [LS -> LS_W] -> WB. The sequencer handshakes with the
//   fetch and load/store ports and gates the decoder write enables so that
//   architectural state commits exactly once per instruction, in S_WB.
//
//   Optional feature macro: YSYX_23060075_SEQ_TIMEOUT_EN
//     When defined, a per-phase wait counter sends the sequencer to a sticky
//     error state after TIMEOUT_CYCLES cycles without the awaited handshake.
//     When undefined, the sequencer waits forever and bus_err is tied to 0.
//
// Ports
//   clk, rst                         clock, async active-high reset
//   if_req_valid / if_req_ready      fetch request handshake
//   if_resp_valid, inst_reg_en       fetch response, instruction register load
//   dec_mem_r_en/dec_mem_w_en        decoded load/store
//   dec_gpr_w_en/dec_csr_w_en        decoded register write enables
//   halt_req                         decoded ebreak
//   ls_req_valid / ls_req_ready      load/store request handshake
//   ls_resp_valid                    load data / store acknowledge
//   mem_r_en, mem_w_en               gated memory strobes
//   gpr_w_en, csr_w_en, pc_en        commit strobes (S_WB only)
//   halted, bus_err                  status
//   inst_cnt                         retired instruction count
module ysyx_23060075_mc_sequencer #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  output logic        if_req_valid,
  input  logic        if_req_ready,
  input  logic        if_resp_valid,
  output logic        inst_reg_en,
  input  logic        dec_mem_r_en,
  input  logic        dec_mem_w_en,
  input  logic        dec_gpr_w_en,
  input  logic        dec_csr_w_en,
  input  logic        halt_req,
  output logic        ls_req_valid,
  input  logic        ls_req_ready,
  input  logic        ls_resp_valid,
  output logic        mem_r_en,
  output logic        mem_w_en,
  output logic        gpr_w_en,
  output logic        csr_w_en,
  output logic        pc_en,
  output logic        halted,
  output logic        bus_err,
  output logic [31:0] inst_cnt
);

  typedef enum logic [3:0] {
    S_IDLE, S_IF, S_IF_W, S_EX, S_LS, S_LS_W, S_WB, S_HALT, S_ERR
  } state_t;

  state_t state, state_n;

`ifdef YSYX_23060075_SEQ_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wait_cnt;
  logic          in_wait;
  logic          tmo;

  assign in_wait = (state == S_IF) || (state == S_IF_W) ||
                   (state == S_LS) || (state == S_LS_W);
  // Trips on the cycle where the count would reach TIMEOUT_CYCLES, so the
  // sequencer leaves after exactly TIMEOUT_CYCLES cycles in one wait state.
  assign tmo = in_wait && ((wait_cnt + CW'(1)) == CW'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                wait_cnt <= '0;
    else if (state_n != state || !in_wait)  wait_cnt <= '0;
    else                                    wait_cnt <= wait_cnt + CW'(1);
  end
`else
  logic [15:0] unused_timeout;
  assign unused_timeout = 16'(TIMEOUT_CYCLES);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 inst_cnt <= '0;
    else if (state == S_WB)  inst_cnt <= inst_cnt + 32'd1;
  end

  always_comb begin
    state_n      = state;
    if_req_valid = 1'b0;
    inst_reg_en  = 1'b0;
    ls_req_valid = 1'b0;
    mem_r_en     = 1'b0;
    mem_w_en     = 1'b0;
    gpr_w_en     = 1'b0;
    csr_w_en     = 1'b0;
    pc_en        = 1'b0;
    halted       = 1'b0;
    bus_err      = 1'b0;
    unique case (state)
      S_IDLE: state_n = S_IF;
      S_IF: begin
        if_req_valid = 1'b1;
        if (if_req_ready) state_n = S_IF_W;
      end
      // A response during S_IF is never looked at: it must follow acceptance.
      S_IF_W: begin
        if (if_resp_valid) begin
          inst_reg_en = 1'b1;
          state_n     = S_EX;
        end
      end
      S_EX: state_n = (dec_mem_r_en || dec_mem_w_en) ? S_LS : S_WB;
      S_LS: begin
        ls_req_valid = 1'b1;
        mem_r_en     = dec_mem_r_en;
        mem_w_en     = dec_mem_w_en;
        if (ls_req_ready) state_n = S_LS_W;
      end
      S_LS_W: begin
        mem_r_en = dec_mem_r_en;
        mem_w_en = dec_mem_w_en;
        if (ls_resp_valid) state_n = S_WB;
      end
      S_WB: begin
        pc_en    = 1'b1;
        gpr_w_en = dec_gpr_w_en;
        csr_w_en = dec_csr_w_en;
        state_n  = halt_req ? S_HALT : S_IF;
      end
      S_HALT: halted = 1'b1;
`ifdef YSYX_23060075_SEQ_TIMEOUT_EN
      S_ERR: bus_err = 1'b1;
`else
      S_ERR: state_n = S_ERR;
`endif
      default: state_n = S_IDLE;
    endcase
`ifdef YSYX_23060075_SEQ_TIMEOUT_EN
    // The awaited handshake wins over the timeout on the deciding cycle.
    if (tmo && state_n == state) state_n = S_ERR;
`endif
  end

endmodule

// File: tb/tb_ysyx_23060075_mc_sequencer.sv
module tb_ysyx_23060075_mc_sequencer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req_valid, if_req_ready, if_resp_valid, inst_reg_en;
  logic        dec_mem_r_en, dec_mem_w_en, dec_gpr_w_en, dec_csr_w_en, halt_req;
  logic        ls_req_valid, ls_req_ready, ls_resp_valid;
  logic        mem_r_en, mem_w_en, gpr_w_en, csr_w_en, pc_en, halted, bus_err;
  logic [31:0] inst_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ysyx_23060075_mc_sequencer #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready),
    .if_resp_valid(if_resp_valid), .inst_reg_en(inst_reg_en),
    .dec_mem_r_en(dec_mem_r_en), .dec_mem_w_en(dec_mem_w_en),
    .dec_gpr_w_en(dec_gpr_w_en), .dec_csr_w_en(dec_csr_w_en),
    .halt_req(halt_req),
    .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready),
    .ls_resp_valid(ls_resp_valid),
    .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
    .gpr_w_en(gpr_w_en), .csr_w_en(csr_w_en), .pc_en(pc_en),
    .halted(halted), .bus_err(bus_err), .inst_cnt(inst_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [9:0] outs1();
    return {if_req_valid, inst_reg_en, ls_req_valid, mem_r_en, mem_w_en,
            gpr_w_en, csr_w_en, pc_en, halted, bus_err};
  endfunction

  logic [39:0] v_pc, v_gpr, v_csr, v_ire, v_ifv;
  logic [9:0]  v_mr, v_lsv, v_g;
  logic [6:0]  s_mw, s_mr, s_g, s_pc;

  initial begin
    if_req_ready = 0; if_resp_valid = 0; ls_req_ready = 0; ls_resp_valid = 0;
    dec_mem_r_en = 0; dec_mem_w_en = 0; dec_gpr_w_en = 0; dec_csr_w_en = 0;
    halt_req = 0;

    // Reset state
    step(); step();
    chk("reset_outs", 64'(outs1()), 64'd0);
    chk("reset_cnt", 64'(inst_cnt), 64'd0);
    rst = 0;
    #1;
    chk("release_no_req", 64'(if_req_valid), 64'd0);
    step();
    chk("first_if_req", 64'(if_req_valid), 64'd1);

    // Zero-wait ALU instructions: 10 x 4 cycles
    if_req_ready = 1; if_resp_valid = 1; ls_req_ready = 1; ls_resp_valid = 1;
    dec_gpr_w_en = 1; dec_csr_w_en = 1;
    for (int i = 0; i < 40; i++) begin
      v_pc[i] = pc_en; v_gpr[i] = gpr_w_en; v_csr[i] = csr_w_en;
      v_ire[i] = inst_reg_en; v_ifv[i] = if_req_valid;
      step();
    end
    chk("alu_pc_en", 64'(v_pc), 64'h88_8888_8888);
    chk("alu_gpr_w", 64'(v_gpr), 64'h88_8888_8888);
    chk("alu_csr_w", 64'(v_csr), 64'h88_8888_8888);
    chk("alu_ire", 64'(v_ire), 64'h22_2222_2222);
    chk("alu_ifv", 64'(v_ifv), 64'h11_1111_1111);
    chk("alu_cnt", 64'(inst_cnt), 64'd10);

    // Load: ls_req_ready on the 3rd LS cycle, response on the 2nd LS_W cycle
    dec_csr_w_en = 0; dec_mem_r_en = 1;
    for (int i = 0; i < 10; i++) begin
      ls_req_ready  = (i == 5);
      ls_resp_valid = (i == 7);
      #1;
      v_mr[i] = mem_r_en; v_lsv[i] = ls_req_valid; v_g[i] = gpr_w_en;
      if (i < 9) step();
    end
    chk("ld_mem_r", 64'(v_mr), 64'b00_1111_1000);
    chk("ld_lsv", 64'(v_lsv), 64'b00_0011_1000);
    chk("ld_gpr", 64'(v_g), 64'b01_0000_0000);
    chk("ld_next_if", 64'(if_req_valid), 64'd1);
    chk("ld_cnt", 64'(inst_cnt), 64'd11);

    // Store, no GPR write, zero wait
    dec_mem_r_en = 0; dec_mem_w_en = 1; dec_gpr_w_en = 0;
    ls_req_ready = 1; ls_resp_valid = 1;
    for (int i = 0; i < 7; i++) begin
      s_mw[i] = mem_w_en; s_mr[i] = mem_r_en; s_g[i] = gpr_w_en; s_pc[i] = pc_en;
      if (i < 6) step();
    end
    chk("st_mem_w", 64'(s_mw), 64'b001_1000);
    chk("st_mem_r", 64'(s_mr), 64'd0);
    chk("st_gpr", 64'(s_g), 64'd0);
    chk("st_pc", 64'(s_pc), 64'b010_0000);
    chk("st_cnt", 64'(inst_cnt), 64'd12);

    // Reset during an outstanding load (S_LS_W)
    dec_mem_w_en = 0; dec_mem_r_en = 1; dec_gpr_w_en = 1; ls_resp_valid = 0;
    for (int i = 0; i < 4; i++) step();
    chk("lsw_mem_r", 64'(mem_r_en), 64'd1);
    rst = 1;
    #1;
    chk("abort_outs", 64'(outs1()), 64'd0);
    chk("abort_cnt", 64'(inst_cnt), 64'd0);
    step();
    rst = 0;
    dec_mem_r_en = 0; dec_gpr_w_en = 1; ls_resp_valid = 1;
    #1;
    chk("abort_idle", 64'(if_req_valid), 64'd0);
    step();
    chk("abort_refetch", 64'(if_req_valid), 64'd1);

    // ebreak
    halt_req = 1;
    step(); step(); step();
    chk("brk_wb_pc", 64'(pc_en), 64'd1);
    step();
    chk("brk_halted", 64'(halted), 64'd1);
    chk("brk_cnt", 64'(inst_cnt), 64'd1);
    step(); step(); step();
    chk("brk_stay", 64'({halted, if_req_valid, pc_en, gpr_w_en}), 64'b1000);
    chk("brk_cnt_frozen", 64'(inst_cnt), 64'd1);
    rst = 1;
    #1;
    chk("brk_rst_outs", 64'(outs1()), 64'd0);
    chk("brk_rst_cnt", 64'(inst_cnt), 64'd0);
    step();
    halt_req = 0;
    rst = 0;

    // Fetch response never arrives
    if_resp_valid = 0;
    step(); step();
    chk("tmo_in_ifw", 64'({if_req_valid, bus_err}), 64'd0);
`ifdef YSYX_23060075_SEQ_TIMEOUT_EN
    step(); step(); step();
    chk("tmo_not_yet", 64'(bus_err), 64'd0);
    step();
    chk("tmo_err", 64'(bus_err), 64'd1);
    for (int i = 0; i < 5; i++) step();
    if_resp_valid = 1;
    #1;
    chk("tmo_sticky", 64'({bus_err, inst_reg_en, if_req_valid}), 64'b100);
`else
    for (int i = 0; i < 20; i++) step();
    chk("wait_no_err", 64'({bus_err, if_req_valid}), 64'd0);
    if_resp_valid = 1;
    #1;
    chk("wait_still_ifw", 64'(inst_reg_en), 64'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
